// File: rtl/axil_pkg.sv
// Shared types for the AXI-lite write queue: FSM states, response codes and
// the queued command record (sized for the widest legal address/data).
package axil_pkg;

  localparam int AXIL_ADDR_MAX = 64;
  localparam int AXIL_DATA_MAX = 64;
  localparam int AXIL_STRB_MAX = AXIL_DATA_MAX / 8;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } wq_state_e;

  typedef struct packed {
    logic [AXIL_ADDR_MAX-1:0] addr;
    logic [AXIL_DATA_MAX-1:0] data;
    logic [AXIL_STRB_MAX-1:0] strb;
  } cmd_t;

endpackage

// File: rtl/axil_cmd_fifo.sv
// Synchronous command FIFO: power-of-two depth, wrapping pointers, occupancy out.
module axil_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axil_write_queue.sv
// Queued AXI-lite write master: cfg writes are buffered and issued one at a time.
// Optional per-transaction watchdog enabled by defining AXIL_WR_TIMEOUT_EN.
module axil_write_queue
  import axil_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          s_axi_cfg_wvalid,
  output logic                          s_axi_cfg_wready,
  input  logic [ADDR_W-1:0]             s_axi_cfg_waddr,
  input  logic [DATA_W-1:0]             s_axi_cfg_wdata,
  input  logic [DATA_W/8-1:0]           s_axi_cfg_wstrb,
  output logic [ADDR_W-1:0]             s_axi_awaddr,
  output logic                          s_axi_awvalid,
  input  logic                          s_axi_awready,
  output logic [DATA_W-1:0]             s_axi_wdata,
  output logic [DATA_W/8-1:0]           s_axi_wstrb,
  output logic                          s_axi_wvalid,
  input  logic                          s_axi_wready,
  input  logic                          s_axi_bvalid,
  input  logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bready,
  output logic                          err_valid,
  output logic [1:0]                    err_resp,
  output logic [ADDR_W-1:0]             err_addr,
  output logic                          timeout,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int STRB_W = DATA_W / 8;

  wq_state_e         state, state_n;
  cmd_t              cmd_in, head, cmd_q;
  logic              full, empty, head_vis, rst_done;
  logic              push, pop, to_hit;
  logic              aw_n, w_n, b_n, err_n;
  logic [1:0]        err_resp_n;
  logic [ADDR_W-1:0] err_addr_n;

  assign s_axi_cfg_wready = rst_done && !full;
  assign push             = s_axi_cfg_wvalid && s_axi_cfg_wready;

  assign cmd_in = '{addr: AXIL_ADDR_MAX'(s_axi_cfg_waddr),
                    data: AXIL_DATA_MAX'(s_axi_cfg_wdata),
                    strb: AXIL_STRB_MAX'(s_axi_cfg_wstrb)};

  axil_cmd_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk  (s_axi_aclk),
    .grst_n(s_axi_aresetn),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign s_axi_awaddr = ADDR_W'(cmd_q.addr);
  assign s_axi_wdata  = DATA_W'(cmd_q.data);
  assign s_axi_wstrb  = STRB_W'(cmd_q.strb);
  assign busy         = (state != IDLE) || (level != '0);

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Held at zero in IDLE, so it restarts from zero on every SEND entry.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)    to_cnt <= '0;
    else if (state == IDLE) to_cnt <= '0;
    else                    to_cnt <= to_cnt + TO_W'(1);
  end

  assign to_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) timeout <= 1'b0;
    else                timeout <= to_hit;
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    aw_n       = s_axi_awvalid;
    w_n        = s_axi_wvalid;
    b_n        = s_axi_bready;
    pop        = 1'b0;
    err_n      = 1'b0;
    err_resp_n = err_resp;
    err_addr_n = err_addr;
    case (state)
      // head_vis delays the pop one cycle so a fresh push settles first
      IDLE: if (!empty && head_vis) begin
        pop     = 1'b1;
        aw_n    = 1'b1;
        w_n     = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        aw_n = s_axi_awvalid && !s_axi_awready;
        w_n  = s_axi_wvalid && !s_axi_wready;
        if (!aw_n && !w_n) begin
          b_n     = 1'b1;
          state_n = RESP;
        end
      end
      RESP: if (s_axi_bvalid) begin
        b_n     = 1'b0;
        state_n = IDLE;
        if (s_axi_bresp != OKAY) begin
          err_n      = 1'b1;
          err_resp_n = s_axi_bresp;
          err_addr_n = ADDR_W'(cmd_q.addr);
        end
      end
      default: state_n = IDLE;
    endcase
    if (to_hit) begin
      aw_n       = 1'b0;
      w_n        = 1'b0;
      b_n        = 1'b0;
      state_n    = IDLE;
      err_n      = 1'b1;
      err_resp_n = SLVERR;
      err_addr_n = ADDR_W'(cmd_q.addr);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state         <= IDLE;
      s_axi_awvalid <= 1'b0;
      s_axi_wvalid  <= 1'b0;
      s_axi_bready  <= 1'b0;
      err_valid     <= 1'b0;
      err_resp      <= 2'b00;
      err_addr      <= '0;
      cmd_q         <= '0;
      head_vis      <= 1'b0;
      rst_done      <= 1'b0;
    end else begin
      state         <= state_n;
      s_axi_awvalid <= aw_n;
      s_axi_wvalid  <= w_n;
      s_axi_bready  <= b_n;
      err_valid     <= err_n;
      err_resp      <= err_resp_n;
      err_addr      <= err_addr_n;
      if (pop) cmd_q <= head;
      head_vis      <= !empty;
      rst_done      <= 1'b1;
    end
  end

endmodule
